rx_mf_slicer: RTL and testbench
===============================

// Module: rx_mf_slicer
// PURPOSE
//   Receive-side companion to the TX SRRC pulse-shaping filter.
//   Applies the 21-tap symmetric matched filter at 4 samples/symbol, decimates to the symbol rate at a selectable phase,
//   and slices each symbol instant to a 2-bit 4-ASK decision.
//   The decision threshold is adaptive: the mean |y| over blocks of symbols.
//   Sits between the channel/ADC sample stream and the symbol-error counter.
// PARAMETERS
//   SPS         4      samples per symbol; the sample counter wraps at SPS-1
//   LOG2_AVG    6      threshold averaging block = 2^LOG2_AVG symbols
//   THRESH_INIT 43690  slicer threshold (1s17) used until the first block estimate completes
// PORTS
//   clk        in   1   clock
//   reset      in   1   synchronous, active-high
//   in_valid   in   1   x_in is a new sample this cycle
//   x_in       in   18  received sample, 1s17 signed
//   phase      in   2   symbol-instant sample index, 0..SPS-1
//   mf_out     out  18  matched-filter output, 1s17 signed, saturated
//   mf_valid   out  1   mf_out is a new sample this cycle
//   sym_valid  out  1   sym and sym_y are a new decision this cycle (1-cycle pulse)
//   sym        out  2   decision: 00=-3a, 01=-a, 10=+a, 11=+3a
//   sym_y      out  18  mf_out value sampled at the symbol instant
//   thresh     out  18  current slicer threshold, 1s17
//   est_valid  out  1   sticky; set when the first averaging block completes
// BEHAVIOUR
//   Reset (synchronous, active-high):
//     - Delay line, pipeline, counters and accumulator clear to 0.
//     - All outputs are 0, except thresh=THRESH_INIT. est_valid=0.
//   Delay line x[0..20]:
//     - Shifts only on in_valid; x[0]<=x_in.
//     - With in_valid=0 the delay line holds and no valid is generated.
//   Coefficients h[k], 0s18, with h[20-k]=h[k]; k=0..10:
//     1194 2452 1658 -3142 -10432 -13698 -4326 21804 58858 91953 105245
//   Pipeline (valid bit travels with data; no stalls):
//     - S1: p[k]=x[k]+x[20-k] for k=0..9, 19-bit, no overflow possible; p[10]=x[10] sign-extended.
//     - S2: m[k]=p[k]*h[k], full 37-bit product.
//     - S3: acc = sum of m[k], 41-bit; r=(acc+2^17)>>>18; saturate to [-131072,131071]; register mf_out/mf_valid.
//     - Latency: mf_valid is high exactly 3 clk after the in_valid cycle, which then becomes the first output of that sample.
//     - Back-to-back in_valid gives back-to-back mf_valid.
//   Decimation:
//     - The 2-bit sample counter increments on every in_valid and wraps SPS-1 -> 0.
//     - The counter value is tagged onto the sample and travels down the pipeline.
//     - phase is captured into phase_r on reset and whenever in_valid arrives with counter==SPS-1, so a mid-symbol phase change takes effect at the next symbol boundary.
//     - A sample whose tag==phase_r is a symbol instant.
//   Slicer (1 clk after mf_valid):
//     - sym_valid=1; sym_y=mf_out.
//     - sym = 00 if y < -T; 01 if -T <= y < 0; 10 if 0 <= y < T; 11 if y >= T (T=thresh).
//   Threshold estimator:
//     - On each symbol instant, add |y| to a (18+LOG2_AVG)-bit accumulator; |-131072| clamps to 131071.
//     - After 2^LOG2_AVG symbols: thresh<=acc>>LOG2_AVG (floor), then acc clears, est_valid<=1.
//     - The new thresh applies from the next symbol onward.
//   Simultaneous events: reset wins over in_valid, a phase update and a block completion.
//   Reset mid-stream: in-flight pipeline samples are discarded and no valid pulses follow.
// TESTING
//   1. Impulse: x_in=131071 once, then zeros, all in_valid=1.
//      -> 21 mf_out values: 597, 1226, 829, -1571, ..., center 52622, mirrored symmetric; first value 3 clk after the impulse.
//   2. DC: constant x_in=43690 for >=21 samples -> mf_out settles at 66313.
//      Constant 131071 -> mf_out saturates at 131071.
//   3. Gapped input: in_valid 1-of-3 with the impulse of test 1
//      -> identical mf_out sequence; each mf_valid 3 clk after its in_valid.
//   4. Decimation: phase=2, counter aligned from reset -> sym_valid exactly every 4th mf_valid, on tag 2.
//      Change phase to 0 mid-symbol -> the switch happens only after the next counter wrap.
//   5. Slicer/estimator: TX symbols {-3,-1,1,3}/3 repeating at full scale through ideal taps.
//      -> decisions 00,01,10,11 match; est_valid=1 after 64 symbols; thresh within 1% of the mean |sym_y|.
//   6. Reset mid-stream: assert reset for 1 clk during test 5
//      -> the next cycle has all outputs 0, thresh=43690, est_valid=0; no sym_valid until the pipeline refills.

Source files
------------

// File: rtl/rx_mf_slicer.sv
// rx_mf_slicer: 21-tap symmetric matched filter at SPS samples/symbol,
// symbol-rate decimation at a selectable phase, and a 4-ASK slicer whose
// threshold tracks the block mean of |y| at the symbol instants.
//
// Handshake: in_valid qualifies x_in for exactly one cycle. There is no
// backpressure. mf_valid qualifies mf_out for one cycle. sym_valid qualifies
// sym and sym_y for one cycle. Each output holds its value between pulses.
module rx_mf_slicer #(
    parameter int SPS         = 4,
    parameter int LOG2_AVG    = 6,
    parameter int THRESH_INIT = 43690
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic signed [17:0] x_in,
    input  logic        [1:0]  phase,
    output logic signed [17:0] mf_out,
    output logic               mf_valid,
    output logic               sym_valid,
    output logic        [1:0]  sym,
    output logic signed [17:0] sym_y,
    output logic signed [17:0] thresh,
    output logic               est_valid
);

    localparam int         ACCW    = 18 + LOG2_AVG;
    localparam logic [1:0] CNT_MAX = 2'(SPS - 1);

    // Half of the symmetric tap set, 0s18 format; h[20-k] == h[k].
    function automatic logic signed [17:0] coef(input int k);
        case (k)
            0:       coef = 18'sd1194;
            1:       coef = 18'sd2452;
            2:       coef = 18'sd1658;
            3:       coef = -18'sd3142;
            4:       coef = -18'sd10432;
            5:       coef = -18'sd13698;
            6:       coef = -18'sd4326;
            7:       coef = 18'sd21804;
            8:       coef = 18'sd58858;
            9:       coef = 18'sd91953;
            10:      coef = 18'sd105245;
            default: coef = 18'sd0;
        endcase
    endfunction

    logic signed [17:0] x_dl [0:20];
    logic               v0, v1, v2;
    logic        [1:0]  cnt, phase_r;
    logic        [1:0]  tag0, tag1, tag2, tag3;
    logic        [1:0]  ph0, ph1, ph2, ph3;
    logic signed [18:0] p [0:10];
    logic signed [36:0] m [0:10];
    logic signed [40:0] acc_sum, acc_rnd, acc_shr;
    logic signed [17:0] mf_sat, neg_thresh;
    logic        [17:0] abs_y;
    logic        [1:0]  sym_next;
    logic               is_sym;
    logic [ACCW-1:0]    est_acc, sum_next;
    logic [LOG2_AVG-1:0] sym_cnt;

    // Delay line, sample counter and phase latch. Each sample is tagged with
    // its counter value and with the phase in force for its symbol; phase is
    // only re-latched on the last sample of a symbol.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 21; i++) x_dl[i] <= '0;
            v0      <= 1'b0;
            tag0    <= '0;
            ph0     <= '0;
            cnt     <= '0;
            phase_r <= phase;
        end else begin
            v0 <= in_valid;
            if (in_valid) begin
                x_dl[0] <= x_in;
                for (int i = 1; i < 21; i++) x_dl[i] <= x_dl[i-1];
                tag0 <= cnt;
                ph0  <= phase_r;
                if (cnt == CNT_MAX) begin
                    cnt     <= '0;
                    phase_r <= phase;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

    // S1: fold symmetric taps into pre-adds.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 11; k++) p[k] <= '0;
            v1   <= 1'b0;
            tag1 <= '0;
            ph1  <= '0;
        end else begin
            for (int k = 0; k < 10; k++) p[k] <= 19'(x_dl[k]) + 19'(x_dl[20-k]);
            p[10] <= 19'(x_dl[10]);
            v1    <= v0;
            tag1  <= tag0;
            ph1   <= ph0;
        end
    end

    // S2: full-precision coefficient products.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 11; k++) m[k] <= '0;
            v2   <= 1'b0;
            tag2 <= '0;
            ph2  <= '0;
        end else begin
            for (int k = 0; k < 11; k++) m[k] <= 37'(p[k]) * 37'(coef(k));
            v2   <= v1;
            tag2 <= tag1;
            ph2  <= ph1;
        end
    end

    // S3 datapath: sum, round half up, drop 18 fraction bits, saturate.
    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < 11; k++) acc_sum = acc_sum + 41'(m[k]);
        acc_rnd = acc_sum + 41'sd131072;
        acc_shr = acc_rnd >>> 18;
        if (acc_shr > 41'sd131071)       mf_sat = {1'b0, {17{1'b1}}};
        else if (acc_shr < -41'sd131072) mf_sat = {1'b1, 17'd0};
        else                             mf_sat = acc_shr[17:0];
    end

    // S3 register: filter output with its tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            mf_out   <= '0;
            mf_valid <= 1'b0;
            tag3     <= '0;
            ph3      <= '0;
        end else begin
            mf_out   <= mf_sat;
            mf_valid <= v2;
            tag3     <= tag2;
            ph3      <= ph2;
        end
    end

    // Slicer decision and |y| for the estimator; -131072 clamps to 131071.
    always_comb begin
        is_sym     = mf_valid && (tag3 == ph3);
        neg_thresh = -thresh;
        if (mf_out == {1'b1, 17'd0}) abs_y = 18'd131071;
        else if (mf_out < 18'sd0)    abs_y = 18'(-mf_out);
        else                         abs_y = 18'(mf_out);
        if (mf_out < neg_thresh)     sym_next = 2'b00;
        else if (mf_out < 18'sd0)    sym_next = 2'b01;
        else if (mf_out < thresh)    sym_next = 2'b10;
        else                         sym_next = 2'b11;
        sum_next = est_acc + ACCW'(abs_y);
    end

    // Decision register and block-mean threshold estimator. The symbol that
    // completes a block is still sliced with the old threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_valid <= 1'b0;
            sym       <= '0;
            sym_y     <= '0;
            thresh    <= 18'(THRESH_INIT);
            est_valid <= 1'b0;
            est_acc   <= '0;
            sym_cnt   <= '0;
        end else begin
            sym_valid <= is_sym;
            if (is_sym) begin
                sym     <= sym_next;
                sym_y   <= mf_out;
                sym_cnt <= sym_cnt + 1'b1;
                if (sym_cnt == '1) begin
                    thresh    <= $signed(sum_next[LOG2_AVG +: 18]);
                    est_acc   <= '0;
                    est_valid <= 1'b1;
                end else begin
                    est_acc <= sum_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_mf_slicer.sv
// Directed bench for rx_mf_slicer: impulse, DC/saturation, gapped input,
// decimation phase switching, slicer/estimator stream, reset mid-stream.
module tb_rx_mf_slicer;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [17:0] x_in = '0;
    logic        [1:0]  phase = 2'd2;
    logic signed [17:0] mf_out;
    logic               mf_valid;
    logic               sym_valid;
    logic        [1:0]  sym;
    logic signed [17:0] sym_y;
    logic signed [17:0] thresh;
    logic               est_valid;

    rx_mf_slicer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .phase     (phase),
        .mf_out    (mf_out),
        .mf_valid  (mf_valid),
        .sym_valid (sym_valid),
        .sym       (sym),
        .sym_y     (sym_y),
        .thresh    (thresh),
        .est_valid (est_valid)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- observation queues ----------------
    int                 in_t[$];
    int                 mf_t[$];
    int                 sym_t[$];
    logic signed [17:0] mf_q[$];
    logic signed [17:0] sy_q[$];
    logic        [1:0]  sc_q[$];
    logic               ev_q[$];
    logic signed [17:0] exp_q[$];

    // Edge index at which an input sample was accepted.
    always @(posedge clk) if (!reset && in_valid) in_t.push_back(cyc);

    // Outputs sampled on the falling edge; stamp with the preceding edge index.
    always @(negedge clk) begin
        if (mf_valid) begin
            mf_q.push_back(mf_out);
            mf_t.push_back(cyc - 1);
        end
        if (sym_valid) begin
            sy_q.push_back(sym_y);
            sc_q.push_back(sym);
            ev_q.push_back(est_valid);
            sym_t.push_back(cyc - 1);
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic signed [47:0] got,
                         input logic signed [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        x_in     = 18'(v);
        tick();
        in_valid = 1'b0;
        x_in     = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic apply_reset(input logic [1:0] ph);
        phase    = ph;
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_obs();
        in_t.delete(); mf_t.delete(); sym_t.delete(); mf_q.delete();
        sy_q.delete(); sc_q.delete(); ev_q.delete(); exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_mf_out"},    mf_out,    0);
        check({pfx, "_mf_valid"},  mf_valid,  0);
        check({pfx, "_sym_valid"}, sym_valid, 0);
        check({pfx, "_sym"},       sym,       0);
        check({pfx, "_sym_y"},     sym_y,     0);
        check({pfx, "_thresh"},    thresh,    43690);
        check({pfx, "_est_valid"}, est_valid, 0);
    endtask

    // ---------------- reference data ----------------
    // Impulse response for a 131071 impulse: round(131071*h/2^18).
    int imp_tab[21] = '{597, 1226, 829, -1571, -5216, -6849, -2163, 10902, 29429,
                        45976, 52622, 45976, 29429, 10902, -2163, -6849, -5216,
                        -1571, 829, 1226, 597};
    int h_tab[21]   = '{1194, 2452, 1658, -3142, -10432, -13698, -4326, 21804,
                        58858, 91953, 105245, 91953, 58858, 21804, -4326, -13698,
                        -10432, -3142, 1658, 2452, 1194};
    int amp[4]      = '{-131071, -43690, 43690, 131071};
    int xs[560];

    function automatic int ref_fir(input int n);
        longint acc = 0;
        longint r;
        for (int k = 0; k < 21; k++)
            if (n - k >= 0) acc += longint'(h_tab[k]) * longint'(xs[n-k]);
        r = (acc + 131072) >>> 18;
        if (r > 131071)  r = 131071;
        if (r < -131072) r = -131072;
        return int'(r);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int bad;
        int exp_idx[6];
        int t_model, acc_model, cnt_model, y, code, ay;
        logic ev_model;

        // Reset state
        apply_reset(2'd2);
        check_reset_outputs("rst");

        // 1. Impulse, back-to-back
        clear_obs();
        for (int i = 0; i < 21; i++) exp_q.push_back(18'(imp_tab[i]));
        send(131071);
        repeat (24) send(0);
        idle(5);
        check("imp_count", mf_q.size(), 25);
        for (int i = 0; i < 21 && i < mf_q.size(); i++)
            check($sformatf("imp_%0d", i), mf_q[i], exp_q.pop_front());
        if (mf_t.size() > 0 && in_t.size() > 0)
            check("imp_latency", mf_t[0] - in_t[0], 3);
        else
            check("imp_latency_seen", 0, 1);

        // 2. DC settling and saturation both ways
        clear_obs();
        repeat (24) send(43690);
        idle(5);
        check("dc_43690", mf_q.size() > 0 ? mf_q[mf_q.size()-1] : 0, 66313);
        clear_obs();
        repeat (24) send(131071);
        idle(5);
        check("dc_sat_pos", mf_q.size() > 0 ? mf_q[mf_q.size()-1] : 0, 131071);
        clear_obs();
        repeat (24) send(-131072);
        idle(5);
        check("dc_sat_neg", mf_q.size() > 0 ? mf_q[mf_q.size()-1] : 0, -131072);

        // 3. Gapped impulse, in_valid 1 of 3
        apply_reset(2'd0);
        clear_obs();
        send(131071);
        idle(2);
        repeat (24) begin
            send(0);
            idle(2);
        end
        idle(5);
        check("gap_count", mf_q.size(), 25);
        for (int i = 0; i < 21 && i < mf_q.size(); i++)
            check($sformatf("gap_%0d", i), mf_q[i], imp_tab[i]);
        bad = 0;
        for (int i = 0; i < mf_t.size() && i < in_t.size(); i++)
            if (mf_t[i] - in_t[i] != 3) bad++;
        check("gap_latency_bad", bad, 0);

        // 4. Decimation at phase 2, then phase 0 requested on sample 14 (tag 2)
        apply_reset(2'd2);
        clear_obs();
        for (int j = 0; j < 24; j++) begin
            if (j == 14) phase = 2'd0;
            send(j);
        end
        idle(5);
        exp_idx = '{2, 6, 10, 14, 16, 20};
        check("dec_mf_count", mf_t.size(), 24);
        check("dec_sym_count", sym_t.size(), 6);
        if (mf_t.size() == 24)
            for (int i = 0; i < 6 && i < sym_t.size(); i++)
                check($sformatf("dec_sym_%0d", i), sym_t[i], mf_t[exp_idx[i]] + 1);

        // 5. 4-ASK stream, symbols on tag 0, decided at tag 2
        apply_reset(2'd2);
        clear_obs();
        for (int j = 0; j < 560; j++) begin
            xs[j] = (j % 4 == 0) ? amp[(j / 4) % 4] : 0;
            send(xs[j]);
        end
        idle(6);
        check("ask_sym_count", sy_q.size(), 140);
        t_model = 43690; acc_model = 0; cnt_model = 0; ev_model = 1'b0;
        for (int k = 0; k < 140 && k < sy_q.size(); k++) begin
            y = ref_fir(4 * k + 2);
            if (y < -t_model)     code = 0;
            else if (y < 0)       code = 1;
            else if (y < t_model) code = 2;
            else                  code = 3;
            ay = (y == -131072) ? 131071 : ((y < 0) ? -y : y);
            acc_model += ay;
            cnt_model++;
            if (cnt_model == 64) begin
                t_model   = acc_model / 64;
                acc_model = 0;
                cnt_model = 0;
                ev_model  = 1'b1;
            end
            check($sformatf("ask_y_%0d", k), sy_q[k], y);
            check($sformatf("ask_code_%0d", k), sc_q[k], code);
            check($sformatf("ask_est_%0d", k), ev_q[k], ev_model);
            if (k >= 4) check($sformatf("ask_tx_%0d", k), sc_q[k], (k - 2) % 4);
        end
        check("ask_thresh_model", thresh, t_model);
        check("ask_thresh_1pct", (thresh - 33976) * 100 <= 33976 &&
                                 (33976 - thresh) * 100 <= 33976, 1);

        // 6. Reset mid-stream (with in_valid high) after the first estimate
        apply_reset(2'd2);
        for (int j = 0; j < 300; j++) send(xs[j]);
        check("mid_est_before", est_valid, 1);
        reset    = 1'b1;
        in_valid = 1'b1;
        x_in     = 18'sd131071;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        x_in     = '0;
        check_reset_outputs("mid");
        clear_obs();
        idle(6);
        check("mid_no_mf", mf_q.size(), 0);
        check("mid_no_sym", sy_q.size(), 0);
        clear_obs();
        repeat (24) send(0);
        idle(5);
        check("mid_refill_syms", sym_t.size(), 6);
        if (sym_t.size() > 0 && mf_t.size() > 2)
            check("mid_first_sym", sym_t[0], mf_t[2] + 1);
        else
            check("mid_first_sym_seen", 0, 1);
        check("mid_thresh_after", thresh, 43690);
        check("mid_est_after", est_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
